sample_seq_queue: RTL and testbench

SAMPLE_SEQ_QUEUE -- requirements
Module: sample_seq_queue

---
 rtl/sample_seq_queue.sv | 105 ++++++++++
 tb/tb_sample_seq_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_seq_queue.sv
// Stereo sample circular buffer that replays the newest SEQ_LEN samples, oldest first, after each qualifying write.
// Replay latency is 2 edges from the triggering write; writes never stall, and a write during a replay queues exactly one follow-on replay (a further one sets ovr).
module sample_seq_queue #(
  parameter int DEPTH   = 1024,
  parameter int SEQ_LEN = 1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  input  logic        wrt_smpl,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        sequencing,
  output logic        full,
  output logic        ovr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam int SW = $clog2(SEQ_LEN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] SEQ   = 2'd2;

  localparam logic [AW-1:0] LEN_A  = AW'(SEQ_LEN);
  localparam logic [CW-1:0] LEN_C  = CW'(SEQ_LEN);
  localparam logic [SW-1:0] LAST_S = SW'(SEQ_LEN - 1);

  logic [31:0]   ram [DEPTH];
  logic [31:0]   rd_q;
  logic [AW-1:0] wptr;
  logic [AW-1:0] wptr_nxt;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [SW-1:0] seq_cnt;
  logic [1:0]    state;
  logic          pending;
  logic          start;

  always_comb begin
    wptr_nxt = wrt_smpl ? wptr + 1'b1 : wptr;
    cnt_nxt  = (wrt_smpl && (cnt != LEN_C)) ? cnt + 1'b1 : cnt;
    // A same-cycle write while pending merges into the one queued replay.
    start    = (state == IDLE) && (pending || (wrt_smpl && (cnt_nxt == LEN_C)));
  end

  assign full = (cnt == LEN_C);

  // Storage is never reset; the read port runs every cycle and PRIME/SEQ steer rd_ptr.
  always_ff @(posedge clk) begin
    if (wrt_smpl) ram[wptr] <= {lft_smpl, rght_smpl};
    rd_q <= ram[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      seq_cnt    <= '0;
      state      <= IDLE;
      pending    <= 1'b0;
      ovr        <= 1'b0;
      sequencing <= 1'b0;
      lft_out    <= '0;
      rght_out   <= '0;
    end else begin
      wptr       <= wptr_nxt;
      cnt        <= cnt_nxt;
      // Output stage lags the FSM by one cycle to absorb the registered RAM read.
      sequencing <= (state == SEQ);
      if (state == SEQ) {lft_out, rght_out} <= rd_q;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRIME;
            rd_ptr  <= wptr_nxt - LEN_A;
            pending <= 1'b0;
          end
        end
        PRIME: begin
          state   <= SEQ;
          rd_ptr  <= rd_ptr + 1'b1;
          seq_cnt <= '0;
        end
        SEQ: begin
          rd_ptr  <= rd_ptr + 1'b1;
          seq_cnt <= seq_cnt + 1'b1;
          if (seq_cnt == LAST_S) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wrt_smpl && (state != IDLE)) begin
        pending <= 1'b1;
        if (pending) ovr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_seq_queue.sv
// Directed bench: a small instance (DEPTH=8, SEQ_LEN=5) checked against a scoreboard of expected replay windows,
// plus a default-parameter instance checked for one full-length replay.
module tb_sample_seq_queue;

  localparam int SL = 5;
  localparam int BIG_LEN = 1021;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lft_smpl, rght_smpl, lft_out, rght_out;
  logic        wrt_smpl, sequencing, full, ovr;
  logic [15:0] lft_b, rght_b, lo_b, ro_b;
  logic        wrt_b, seq_b, full_b, ovr_b;

  int checks = 0;
  int failures = 0;
  int run, nseq, run_b, nseq_b, kb;
  logic seq_s;
  logic have_last;
  logic [31:0] last_exp;
  logic [31:0] sb [$];
  logic [31:0] hist [$];

  sample_seq_queue #(.DEPTH(8), .SEQ_LEN(SL)) dut (
    .clk(clk), .rst(rst), .lft_smpl(lft_smpl), .rght_smpl(rght_smpl), .wrt_smpl(wrt_smpl),
    .lft_out(lft_out), .rght_out(rght_out), .sequencing(sequencing), .full(full), .ovr(ovr)
  );

  sample_seq_queue u_big (
    .clk(clk), .rst(rst), .lft_smpl(lft_b), .rght_smpl(rght_b), .wrt_smpl(wrt_b),
    .lft_out(lo_b), .rght_out(ro_b), .sequencing(seq_b), .full(full_b), .ovr(ovr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic [31:0] e;
    seq_s = sequencing;
    if (rst) begin
      run = 0; nseq = 0; run_b = 0; nseq_b = 0; kb = 0;
    end else begin
      if (sequencing) begin
        run++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("lft_out", 32'(lft_out), 32'(e[31:16]));
          chk("rght_out", 32'(rght_out), 32'(e[15:0]));
          last_exp = e;
          have_last = 1'b1;
        end
      end else begin
        if (run != 0) begin
          chk("run_len", run, SL);
          run = 0;
          nseq++;
        end
        if (have_last) chk("hold_lft", 32'(lft_out), 32'(last_exp[31:16]));
      end
      if (seq_b) begin
        chk("big_lft", 32'(lo_b), kb + 1);
        kb++;
        run_b++;
      end else if (run_b != 0) begin
        chk("big_run_len", run_b, BIG_LEN);
        run_b = 0;
        nseq_b++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int l);
    lft_smpl  = 16'(l);
    rght_smpl = 16'(-l);
    wrt_smpl  = 1'b1;
    hist.push_back({16'(l), 16'(-l)});
    tick();
    wrt_smpl  = 1'b0;
  endtask

  task automatic push_win();
    for (int i = hist.size() - SL; i < hist.size(); i++) sb.push_back(hist[i]);
  endtask

  task automatic clr_model();
    sb.delete();
    hist.delete();
    have_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wrt_smpl = 1'b0;
    wrt_b = 1'b0;
    clr_model();
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wrt_smpl = 1'b0; lft_smpl = '0; rght_smpl = '0;
    wrt_b = 1'b0; lft_b = '0; rght_b = '0;
    run = 0; nseq = 0; run_b = 0; nseq_b = 0; kb = 0; seq_s = 1'b0;
    have_last = 1'b0; last_exp = '0;

    // Reset state
    tick();
    chk("rst_lft", 32'(lft_out), 0);
    chk("rst_rght", 32'(rght_out), 0);
    chk("rst_seq", 32'(sequencing), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovr", 32'(ovr), 0);
    rst = 1'b0;
    tick();

    // Fill: four writes do nothing visible, the fifth triggers one replay
    for (int l = 1; l <= 4; l++) begin
      wr(l);
      idle(2);
      chk("fill_full", 32'(full), 0);
    end
    chk("fill_noseq", nseq, 0);
    wr(5);
    push_win();
    chk("full_set", 32'(full), 1);
    idle(2);
    chk("lat_edge1", 32'(seq_s), 0);
    tick();
    chk("lat_edge2", 32'(seq_s), 1);
    idle(10);
    chk("fill_nseq", nseq, 1);
    chk("fill_sb_empty", 32'(sb.size()), 0);

    // Pending: one write mid-replay queues one follow-on replay
    do_reset();
    for (int l = 1; l <= 5; l++) wr(l);
    push_win();
    idle(3);
    wr(6);
    push_win();
    idle(20);
    chk("pend_ovr", 32'(ovr), 0);
    chk("pend_nseq", nseq, 2);
    chk("pend_sb_empty", 32'(sb.size()), 0);

    // Overrun: two writes in one replay
    do_reset();
    for (int l = 1; l <= 5; l++) wr(l);
    push_win();
    idle(3);
    wr(6);
    wr(7);
    push_win();
    chk("ovr_set", 32'(ovr), 1);
    idle(20);
    chk("ovr_sticky", 32'(ovr), 1);
    chk("ovr_nseq", nseq, 2);
    chk("ovr_sb_empty", 32'(sb.size()), 0);

    // Wrap: spaced writes, window crosses the wptr wrap
    do_reset();
    for (int l = 1; l <= 12; l++) begin
      wr(l);
      if (hist.size() >= SL) push_win();
      idle(9);
    end
    chk("wrap_nseq", nseq, 8);
    chk("wrap_sb_empty", 32'(sb.size()), 0);

    // Reset in the middle of a replay
    do_reset();
    for (int l = 1; l <= 5; l++) wr(l);
    push_win();
    idle(3);
    rst = 1'b1;
    #1;
    chk("mid_rst_seq", 32'(sequencing), 0);
    chk("mid_rst_lft", 32'(lft_out), 0);
    chk("mid_rst_rght", 32'(rght_out), 0);
    chk("mid_rst_full", 32'(full), 0);
    clr_model();
    idle(2);
    rst = 1'b0;
    tick();
    for (int l = 1; l <= 4; l++) begin
      wr(l + 20);
      idle(3);
    end
    idle(10);
    chk("post_rst_nseq", nseq, 0);
    chk("post_rst_full", 32'(full), 0);

    // Default parameters: one full-length replay
    for (int i = 1; i <= BIG_LEN; i++) begin
      lft_b  = 16'(i);
      rght_b = 16'(-i);
      wrt_b  = 1'b1;
      tick();
    end
    wrt_b = 1'b0;
    chk("big_full", 32'(full_b), 1);
    idle(BIG_LEN + 10);
    chk("big_nseq", nseq_b, 1);
    chk("big_count", kb, BIG_LEN);
    chk("big_ovr", 32'(ovr_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
